id_decode_stage: RTL
====================

Name: id_decode_stage

Overview:
- Instruction-decode stage of the 64-bit five-stage pipeline. It sits between the IF/ID register and the execute stage.
- It decodes the IF/ID instruction and drives rs1/rs2 to the register file. It generates the immediate and main control signals.
- It detects load-use hazards and registers everything into the ID/EX pipeline register.
- It absorbs bubble insertion on stall and wrong-path squash on branch flush.

Parameters:
- XLEN, 64, datapath width: register data, immediate and PC.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- if_pc  in  XLEN  PC of the IF/ID instruction.
- if_instr  in  32  IF/ID instruction word.
- flush  in  1  branch taken in EX; squash the instruction in ID.
- rf_rs1  out  5  register-file read address 1 (combinational, instr[19:15]).
- rf_rs2  out  5  register-file read address 2 (combinational, instr[24:20]).
- rf_rdata1  in  XLEN  register-file read data 1.
- rf_rdata2  in  XLEN  register-file read data 2.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  1/XLEN/XLEN/XLEN/XLEN  registered ID/EX data.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices, for forwarding.
- ex_funct3  out  3  registered; ex_funct7b5  out  1  registered instr[30].
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each  registered controls.
- ex_alu_op  out  2  registered ALU class.
- ex_illegal  out  1  registered; unsupported opcode.

Behaviour:
- Reset is synchronous; all ex_* outputs are 0 on the cycle after reset is sampled high, including ex_valid=0.
- Reset mid-stream discards the ID/EX contents.
- Latency is 1 cycle: inputs sampled at edge N appear on ex_* after edge N.
- Opcode decode, listed as reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op:
  - R 0110011 -> 1,0,0,0,0,0,10
  - I-ALU 0010011 -> 1,0,0,0,1,0,10
  - Load 0000011 -> 1,1,0,1,1,0,00
  - Store 0100011 -> 0,0,1,0,1,0,00
  - Branch 1100011 -> 0,0,0,0,0,1,01
  - Other -> all 0, ex_illegal=1 when if_valid.
- Immediate, sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - R and other: 0.
- The register file writes on the falling edge, so same-cycle WB data is already visible on rf_rdata. The stage has no WB bypass.
- Hazard detection uses the stage's own registered outputs.
  - hazard = if_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 | (uses_rs2 & ex_rd==rs2)).
  - uses_rs2 is true for R, S and B only. rs1 counts as used for all supported opcodes.
- stall = hazard & ~flush.
- Next-state priority for ID/EX:
  - reset -> zero.
  - else flush -> bubble: all controls 0, ex_valid=0, ex_illegal=0.
  - else hazard -> bubble. The IF/ID instruction is re-presented next cycle, since upstream honours stall.
  - else if_valid=0 -> bubble.
  - else load the decoded fields, ex_valid=1.
- Under a bubble, data fields (pc, rdata, imm, indices) may hold any value. A bench checks only the control fields and ex_valid.
- Simultaneous flush and hazard: flush wins and stall=0, so IF is redirected without holding the wrong-path instruction.
- A stall lasts exactly 1 cycle for a single load-use pair. On the next cycle ex_mem_read=0 (bubble), so the hazard clears.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - the 2-bit alu_op encodings;
  - a packed struct ctrl_t for the seven control bits.
- One natural sub-module, imm_gen: a combinational 32-bit instruction to XLEN immediate. The decoder, hazard logic and ID/EX register stay in id_decode_stage.

Test Plan:
- Decode and timing: reset for 2 cycles, then `add x3,x1,x2` (0x002081B3) with rf_rdata1=5, rf_rdata2=7 -> the next cycle shows ex_valid=1, ex_rd=3, ex_rdata1=5, ex_rdata2=7, ex_reg_write=1, ex_alu_op=10, ex_alu_src=0.
- Immediates: `ld x5,-8(x2)` (0xFF813283) -> ex_imm=0xFFFFFFFFFFFFFFF8, mem_read=1, mem_to_reg=1. `sd x5,16(x2)` (0x00513823) -> ex_imm=16, mem_write=1. `beq x1,x2,-4` (0xFE208EE3) -> ex_imm=-4, ex_branch=1.
- Load-use: `ld x5,0(x2)` followed by `add x6,x5,x1` -> stall=1 for exactly 1 cycle, one bubble with ex_valid=0, then add issues with ex_rs1=5.
- rs2 and x0 rules:
  - ld to x5 followed by `addi x6,x0,5` whose instr[24:20] equals 5 -> no stall, because I-type does not use rs2.
  - ld to x0 followed by `add x6,x0,x0` -> no stall.
- Flush priority: load-use pair with flush=1 in the hazard cycle -> stall=0, next ex_valid=0 with all controls 0.
- Reset and illegal:
  - Opcode 0x7F with if_valid=1 -> ex_illegal=1, all controls 0.
  - reset asserted for one cycle while ex_valid=1 -> all ex_* = 0 at the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline.
//   - Opcode constants for the supported instruction classes.
//   - alu_op encodings handed from decode to the execute-stage ALU control.
//   - ctrl_t: the main control bundle produced by decode.
package pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU class: address add, branch compare, or funct-driven operation.
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  // Field order matters: the bench and the execute stage treat this as
  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: turns a 32-bit instruction word into its sign-extended
// XLEN-bit immediate. Purely combinational.
// Ports:
//   instr  in   32    instruction word
//   imm    out  XLEN  sign-extended immediate (0 for R-type and unsupported)
module imm_gen
  import pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  // rs1 and funct3 never contribute to any immediate format here.
  logic unused_fields;
  assign unused_fields = ^instr[19:12];

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: decodes the IF/ID instruction, addresses the
// register file, builds the immediate and main controls, detects load-use
// hazards against the instruction currently in ID/EX, and registers the
// result into the ID/EX pipeline register (1-cycle latency).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_valid/if_pc/if_instr    IF/ID register contents
//   flush                      squash the instruction in ID (taken branch)
//   rf_rs1/rf_rs2              register-file read addresses (combinational)
//   rf_rdata1/rf_rdata2        register-file read data
//   stall                      hold PC and IF/ID this cycle (combinational)
//   ex_*                       registered ID/EX contents
module id_decode_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rdata1,
  output logic [XLEN-1:0] ex_rdata2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic            ex_illegal
);

  // ---------------------------------------------------------------- decode
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] dec_imm;
  ctrl_t           dec_ctrl;
  logic            dec_supported;
  logic            dec_uses_rs2;

  assign opcode = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  always_comb begin
    dec_ctrl      = '0;
    dec_supported = 1'b1;
    dec_uses_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_FUNCT;
        dec_uses_rs2       = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_LOAD: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.alu_op     = ALU_ADD;
      end
      OP_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_BRANCH;
        dec_uses_rs2    = 1'b1;
      end
      default: dec_supported = 1'b0;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (dec_imm)
  );

  // --------------------------------------------------------- ID/EX register
  logic            valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] rdata1_reg;
  logic [XLEN-1:0] rdata2_reg;
  logic [XLEN-1:0] imm_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [4:0]      rd_reg;
  logic [2:0]      funct3_reg;
  logic            funct7b5_reg;
  ctrl_t           ctrl_reg;
  logic            illegal_reg;

  // ---------------------------------------------------------------- hazard
  // Load in EX whose destination feeds the instruction in ID: the loaded
  // value is not available until after MEM, so insert one bubble. x0 is
  // never a real dependency.
  logic hazard;
  assign hazard = if_valid && valid_reg && ctrl_reg.mem_read &&
                  (rd_reg != 5'd0) &&
                  ((rd_reg == rs1) || (dec_uses_rs2 && (rd_reg == rs2)));

  // A flush redirects IF, so holding the wrong-path instruction is pointless.
  assign stall = hazard && !flush;

  logic bubble;
  assign bubble = flush || hazard || !if_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rdata1_reg   <= '0;
      rdata2_reg   <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      funct3_reg   <= '0;
      funct7b5_reg <= 1'b0;
      ctrl_reg     <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      // Data fields are don't-care under a bubble, so they load every cycle
      // and only the controls are gated.
      pc_reg       <= if_pc;
      rdata1_reg   <= rf_rdata1;
      rdata2_reg   <= rf_rdata2;
      imm_reg      <= dec_imm;
      rs1_reg      <= rs1;
      rs2_reg      <= rs2;
      rd_reg       <= rd;
      funct3_reg   <= if_instr[14:12];
      funct7b5_reg <= if_instr[30];
      if (bubble) begin
        valid_reg   <= 1'b0;
        ctrl_reg    <= '0;
        illegal_reg <= 1'b0;
      end else begin
        valid_reg   <= 1'b1;
        ctrl_reg    <= dec_ctrl;
        illegal_reg <= !dec_supported;
      end
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_pc         = pc_reg;
  assign ex_rdata1     = rdata1_reg;
  assign ex_rdata2     = rdata2_reg;
  assign ex_imm        = imm_reg;
  assign ex_rs1        = rs1_reg;
  assign ex_rs2        = rs2_reg;
  assign ex_rd         = rd_reg;
  assign ex_funct3     = funct3_reg;
  assign ex_funct7b5   = funct7b5_reg;
  assign ex_reg_write  = ctrl_reg.reg_write;
  assign ex_mem_read   = ctrl_reg.mem_read;
  assign ex_mem_write  = ctrl_reg.mem_write;
  assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
  assign ex_alu_src    = ctrl_reg.alu_src;
  assign ex_branch     = ctrl_reg.branch;
  assign ex_alu_op     = ctrl_reg.alu_op;
  assign ex_illegal    = illegal_reg;

endmodule
